// File: rtl/ble_pkg.sv
// rtl/ble_pkg.sv - shared BLE CRC-24 constants, state type and LFSR step function
package ble_pkg;

  localparam int                   CRC_WIDTH     = 24;
  localparam logic [CRC_WIDTH-1:0] CRC_POLY_MASK = 24'h00065B;
  localparam logic [CRC_WIDTH-1:0] ADV_CRC_INIT  = 24'h555555;

  typedef enum logic {
    PAYLOAD = 1'b0,
    CRC_OUT = 1'b1
  } crc_state_t;

  // One Galois step of x^24+x^10+x^9+x^6+x^4+x^3+x+1 fed with data bit d
  function automatic logic [CRC_WIDTH-1:0] crc24_step(input logic [CRC_WIDTH-1:0] lfsr,
                                                      input logic                 d);
    logic fb;
    fb = lfsr[CRC_WIDTH-1] ^ d;
    return {lfsr[CRC_WIDTH-2:0], 1'b0} ^ ({CRC_WIDTH{fb}} & CRC_POLY_MASK);
  endfunction

endpackage

// File: rtl/ble_crc24_lfsr.sv
// rtl/ble_crc24_lfsr.sv - 24-bit BLE CRC register with load, step and shift-out controls
module ble_crc24_lfsr
  import ble_pkg::*;
#(
  parameter logic [CRC_WIDTH-1:0] INIT = ADV_CRC_INIT
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 load,
  input  logic [CRC_WIDTH-1:0] load_value,
  input  logic                 step,
  input  logic                 step_bit,
  input  logic                 shift,
  output logic [CRC_WIDTH-1:0] lfsr
);

  // load wins over step, step wins over shift
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr <= INIT;
    end else if (load) begin
      lfsr <= load_value;
    end else if (step) begin
      lfsr <= crc24_step(lfsr, step_bit);
    end else if (shift) begin
      lfsr <= {lfsr[CRC_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/crc24_append.sv
// rtl/crc24_append.sv - bit-serial BLE CRC-24 append stage; CRC_CHECK_EN adds RX check mode
module crc24_append
  import ble_pkg::*;
#(
  parameter logic [CRC_WIDTH-1:0] CRC_INIT_DEFAULT = ADV_CRC_INIT
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 bypass,
  input  logic                 restart,
  input  logic [CRC_WIDTH-1:0] crc_init,
  input  logic                 input_tdata,
  input  logic                 input_tvalid,
  output logic                 input_tready,
  input  logic                 input_tlast,
  output logic                 output_tdata,
  output logic                 output_tvalid,
  input  logic                 output_tready,
`ifdef CRC_CHECK_EN
  input  logic                 check_mode,
  output logic                 crc_done,
  output logic                 crc_ok,
`endif
  output logic                 output_tlast
);

  crc_state_t           state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 lfsr_load, lfsr_step, lfsr_shift;
  logic [CRC_WIDTH-1:0] lfsr;
  logic                 out_free;
  logic                 accept;
  logic                 rx_mode;

`ifdef CRC_CHECK_EN
  logic done_q, done_d;
  logic ok_q, ok_d;
  assign rx_mode  = check_mode;
  assign crc_done = done_q;
  assign crc_ok   = ok_q;
`else
  assign rx_mode = 1'b0;
`endif

  assign out_free     = ~valid_q | output_tready;
  assign input_tready = bypass ? output_tready : ((state_q == PAYLOAD) & out_free);
  assign accept       = ~bypass & input_tvalid & input_tready;

  assign output_tdata  = bypass ? input_tdata  : data_q;
  assign output_tvalid = bypass ? input_tvalid : valid_q;
  assign output_tlast  = bypass ? input_tlast  : last_q;

  ble_crc24_lfsr #(
    .INIT(CRC_INIT_DEFAULT)
  ) u_lfsr (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (lfsr_load),
    .load_value(crc_init),
    .step      (lfsr_step),
    .step_bit  (input_tdata),
    .shift     (lfsr_shift),
    .lfsr      (lfsr)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    lfsr_shift = 1'b0;
`ifdef CRC_CHECK_EN
    done_d     = 1'b0;
    ok_d       = ok_q;
`endif
    // bypass freezes everything, including the output register
    if (!bypass) begin
      if (output_tready) begin
        valid_d = 1'b0;
      end
      if (restart) begin
        lfsr_load = 1'b1;
        state_d   = PAYLOAD;
        cnt_d     = 5'd0;
        data_d    = 1'b0;
        valid_d   = 1'b0;
        last_d    = 1'b0;
`ifdef CRC_CHECK_EN
        ok_d      = 1'b0;
`endif
      end else begin
        case (state_q)
          PAYLOAD: begin
            if (accept) begin
              data_d    = input_tdata;
              valid_d   = 1'b1;
              last_d    = 1'b0;
              lfsr_step = 1'b1;
              if (input_tlast) begin
                if (rx_mode) begin
                  // received CRC already went through the LFSR; rearm for next frame
                  last_d    = 1'b1;
                  lfsr_load = 1'b1;
`ifdef CRC_CHECK_EN
                  done_d    = 1'b1;
                  ok_d      = (crc24_step(lfsr, input_tdata) == '0);
`endif
                end else begin
                  state_d = CRC_OUT;
                  cnt_d   = 5'd0;
                end
              end
            end
          end
          CRC_OUT: begin
            if (out_free) begin
              data_d     = lfsr[CRC_WIDTH-1];
              valid_d    = 1'b1;
              last_d     = (cnt_q == 5'd23);
              lfsr_shift = 1'b1;
              cnt_d      = cnt_q + 5'd1;
              if (cnt_q == 5'd23) begin
                lfsr_load = 1'b1;
                state_d   = PAYLOAD;
                cnt_d     = 5'd0;
              end
            end
          end
          default: state_d = PAYLOAD;
        endcase
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= PAYLOAD;
      cnt_q   <= 5'd0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

`ifdef CRC_CHECK_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      done_q <= 1'b0;
      ok_q   <= 1'b0;
    end else begin
      done_q <= done_d;
      ok_q   <= ok_d;
    end
  end
`endif

endmodule

// File: doc/crc24_append.md
Name: crc24_append

Overview:
- Bit-serial BLE CRC-24 generator that sits directly upstream of the whitening stage in the TX baseband chain.
- Accepts PDU bits (header + payload, LSB-first) on an AXI-Stream-style 1-bit interface and forwards each bit unchanged.
- After the PDU bit marked tlast, it appends 24 CRC bits and drives output tlast on the final CRC bit only.
- The LFSR is preset per connection from crc_init on restart.

Parameters:
- CRC_INIT_DEFAULT, 24'h555555, LFSR preset value loaded while aresetn is low (advertising CRCInit).

Ports:
- aclk  input  1  clock, all logic on rising edge
- aresetn  input  1  reset, asynchronous assert, active-low
- bypass  input  1  1: pure combinational pass-through of all stream signals, no CRC appended
- restart  input  1  synchronous; reload LFSR from crc_init, abort any frame in flight
- crc_init  input  24  CRCInit value; bit 0 loads LFSR position 0
- input_tdata  input  1  PDU bit
- input_tvalid  input  1  PDU bit valid
- input_tready  output  1  block accepts a PDU bit
- input_tlast  input  1  last PDU bit of frame
- output_tdata  output  1  PDU bit or CRC bit
- output_tvalid  output  1  output bit valid
- output_tready  input  1  downstream (whitening) ready
- output_tlast  output  1  last CRC bit of frame

Behaviour:
- Reset state (aresetn low): lfsr=CRC_INIT_DEFAULT, state=PAYLOAD, crc_cnt=0, output_tvalid=0, output_tdata=0, output_tlast=0.
- Outputs are registered, with one output register stage.
  - input_tready = (state==PAYLOAD) & (~output_tvalid | output_tready). This gives full throughput of 1 bit/cycle.
  - Latency is 1 cycle from input accept to output valid.
- LFSR step, applied on each accepted PDU bit d:
  - fb = lfsr[23]^d; new[0]=fb.
  - new[i]=lfsr[i-1]^fb for i in {1,3,4,6,9,10}.
  - new[i]=lfsr[i-1] otherwise.
  - Polynomial is x^24+x^10+x^9+x^6+x^4+x^3+x+1 (mask 24'h00065B).
- State PAYLOAD:
  - On accept, load the output register with tdata=d, tvalid=1, tlast=0.
  - If input_tlast, go to CRC_OUT with crc_cnt=0.
- State CRC_OUT:
  - input_tready=0.
  - Each time the output register is free (~output_tvalid | output_tready), load tdata=lfsr[23], shift lfsr left by one with 0 fill (no feedback), and increment crc_cnt.
  - When crc_cnt==23 is loaded, set tlast=1, go to PAYLOAD, and reload lfsr from crc_init for the next frame.
- Downstream stall: the output register holds all of tdata/tvalid/tlast stable while output_tvalid & ~output_tready. CRC bits are never skipped or duplicated.
- restart has priority over any simultaneous beat:
  - lfsr=crc_init, state=PAYLOAD, crc_cnt=0.
  - Output register cleared (tvalid=0); the partial frame is dropped.
- Asynchronous reset mid-frame: same result as the reset state, with the CRC_INIT_DEFAULT preset.
- bypass=1:
  - input_tready=output_tready; output_tdata/tvalid/tlast mirror the input.
  - Internal state is frozen.
  - Toggling bypass is legal only between frames.
- Frame length is unbounded; a 1-bit PDU still yields exactly 25 output bits.

Optional Feature:
- CRC_CHECK_EN: adds input check_mode and outputs crc_done and crc_ok (each 1 bit, 0 at reset).
- With check_mode=1, the block is RX-side. Every input bit, including the received trailing 24 CRC bits, passes through and feeds the LFSR, and no CRC is appended.
- On the tlast beat, crc_done pulses for 1 cycle, aligned with the output tlast. crc_ok = (post-step lfsr==0) in that same cycle.
- Without the macro, these ports and logic are absent and the block is TX-only.

Decomposition:
- Shared package ble_pkg holds:
  - CRC_WIDTH=24, CRC_POLY_MASK=24'h00065B, ADV_CRC_INIT=24'h555555.
  - Enum crc_state_t {PAYLOAD, CRC_OUT}.
- One sub-module, ble_crc24_lfsr: holds the 24-bit register with load, step(d), and shift-out controls. It is reusable by the RX CRC checker.

Test Plan:
- Reset with crc_init=24'h555555, 8-bit PDU 0x00 continuous, output_tready=1 -> 8 PDU bits then 24 CRC bits equal to the software model, tlast only on bit 32, input_tready=0 for the 24 CRC cycles.
- Same frame with random output_tready (50%) -> bitstream identical to the no-stall run; tdata/tlast stable while stalled.
- Back-to-back frames of 16 and 40 bits with crc_init=24'h123456 -> each CRC matches the model independently (LFSR reloaded between frames).
- restart asserted on the 10th CRC bit, then a new frame -> output_tvalid=0 the next cycle; the new frame's CRC is correct; no residual bits emitted.
- bypass=1 with arbitrary stream -> output equals input cycle-for-cycle, zero latency, no appended bits.
- CRC_CHECK_EN, check_mode=1: feed the TX output of test 1 -> crc_done=1 and crc_ok=1 on tlast; flip one CRC bit -> crc_ok=0.
